// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: steps a single-position datapath until the amount is consumed.
// Optional build macro SHIFT_NIBBLE_STEP_EN: move 4 positions per edge while at least 4 remain.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [AMT_W-1:0] stp;
  logic             op_illegal;

  function automatic logic [WIDTH-1:0] step_one(input logic [2:0] o, input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (o)
      OP_SHR:  return {1'b0, v[WIDTH-1:1]};
      OP_SHRA: return sv >>> 1;
      OP_SHL:  return {v[WIDTH-2:0], 1'b0};
      OP_ROR:  return {v[0], v[WIDTH-1:1]};
      OP_ROL:  return {v[WIDTH-2:0], v[WIDTH-1]};
      default: return v;
    endcase
  endfunction

`ifdef SHIFT_NIBBLE_STEP_EN
  function automatic logic [WIDTH-1:0] step_four(input logic [2:0] o, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    t = v;
    for (int i = 0; i < 4; i++) t = step_one(o, t);
    return t;
  endfunction
`endif

  assign op_illegal = (op > OP_ROL);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    stp     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          work_d  = a;
          cnt_d   = amt;
          err_d   = op_illegal;
          state_d = (amt == '0 || op_illegal) ? DONE : RUN;
        end
      end
      RUN: begin
`ifdef SHIFT_NIBBLE_STEP_EN
        if (cnt_q >= AMT_W'(4)) begin
          work_d = step_four(op_q, work_q);
          stp    = AMT_W'(4);
        end else begin
          work_d = step_one(op_q, work_q);
          stp    = AMT_W'(1);
        end
`else
        work_d = step_one(op_q, work_q);
        stp    = AMT_W'(1);
`endif
        cnt_d = cnt_q - stp;
        if (cnt_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Result is the working register; it only moves during RUN or on an accepted start.
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = work_q;
  assign err    = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed plan vectors plus randomized commands vs. an arithmetic model.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [4:0]  amt = '0;
  logic        busy, done, err;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail = 0;

  shift_seq_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .amt(amt),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] v, input int n);
    logic signed [31:0] s;
    s = v;
    if (n == 0) return v;
    case (o)
      3'd0: return v >> n;
      3'd1: return s >>> n;
      3'd2: return v << n;
      3'd3: return (v >> n) | (v << (32 - n));
      3'd4: return (v << n) | (v >> (32 - n));
      default: return v;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input int n);
    if (o > 3'd4 || n == 0) return 0;
`ifdef SHIFT_NIBBLE_STEP_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Issue one command, scramble inputs after acceptance, and wait for done.
  task automatic exec_cmd(input logic [2:0] o, input logic [31:0] av, input logic [4:0] n,
                          output logic [31:0] r, output logic e, output int lat,
                          output bit busy_ok, output bit tmo);
    @(negedge clk); start = 1'b1; op = o; a = av; amt = n;
    @(negedge clk); start = 1'b0; op = 3'($urandom); a = $urandom; amt = 5'($urandom);
    lat = 0; busy_ok = 1'b1; tmo = 1'b0;
    while (done !== 1'b1 && !tmo) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk); lat++;
      if (lat > 100) tmo = 1'b1;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    r = result; e = err;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctrl: busy/done/err=%b expected 000", {busy, done, err}); end
    n_checks++; if (result !== 32'h0) begin n_fail++;
      $display("FAIL reset_result: got %h expected 00000000", result); end
    start = 1'b1; a = 32'hFFFF_FFFF; amt = 5'd3;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || result !== 32'h0) begin n_fail++;
      $display("FAIL reset_hold: busy=%b result=%h expected 0/00000000", busy, result); end
    start = 1'b0; clr_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [7] = '{3'd4, 3'd4, 3'd1, 3'd0, 3'd2, 3'd3, 3'd0};
    logic [31:0] t_a  [7] = '{32'h0000_0001, 32'h0040_0000, 32'h8000_0000, 32'h8000_0000,
                              32'h0000_000F, 32'h0000_0001, 32'hDEAD_BEEF};
    logic [4:0]  t_n  [7] = '{5'd1, 5'd30, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0};
    logic [31:0] t_r  [7] = '{32'h0000_0002, 32'h0010_0000, 32'hF800_0000, 32'h0800_0000,
                              32'h0000_00F0, 32'h1000_0000, 32'hDEAD_BEEF};
    logic [31:0] r; logic e; int lat; bit bok, tmo;
    for (int i = 0; i < 7; i++) begin
      exec_cmd(t_op[i], t_a[i], t_n[i], r, e, lat, bok, tmo);
      n_checks++; if (tmo) begin n_fail++; $display("FAIL dir%0d_timeout: no done within 100 cycles", i); end
      n_checks++; if (r !== t_r[i]) begin n_fail++;
        $display("FAIL dir%0d_result: got %h expected %h", i, r, t_r[i]); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL dir%0d_err: got %b expected 0", i, e); end
      n_checks++; if (lat != model_lat(t_op[i], int'(t_n[i]))) begin n_fail++;
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, model_lat(t_op[i], int'(t_n[i]))); end
      n_checks++; if (!bok) begin n_fail++; $display("FAIL dir%0d_busy: busy dropped before done", i); end
      @(negedge clk);
      n_checks++; if ({busy, done} !== 2'b00 || result !== t_r[i]) begin n_fail++;
        $display("FAIL dir%0d_idle_hold: busy/done=%b result=%h expected 00/%h", i, {busy, done}, result, t_r[i]); end
    end
  endtask

  task automatic test_illegal_err;
    logic [31:0] r; logic e; int lat; bit bok, tmo;
    exec_cmd(3'b111, 32'hDEAD_BEEF, 5'd9, r, e, lat, bok, tmo);
    n_checks++; if (tmo || e !== 1'b1 || r !== 32'hDEAD_BEEF || lat != 0) begin n_fail++;
      $display("FAIL illegal_op: err=%b result=%h lat=%0d expected 1/deadbeef/0", e, r, lat); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL err_hold: err=%b busy=%b expected 1/0", err, busy); end
    start = 1'b1; op = 3'd2; a = 32'h1; amt = 5'd2;
    @(negedge clk); start = 1'b0;
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL err_clear: err=%b busy=%b expected 0/1", err, busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    n_checks++; if (done !== 1'b1 || result !== 32'h4) begin n_fail++;
      $display("FAIL err_clear_cmd: done=%b result=%h expected 1/00000004", done, result); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'h0000_0003; amt = 5'd20;
    @(negedge clk); op = 3'd0; a = 32'hFFFF_FFFF; amt = 5'd1;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || result !== 32'h0030_0000 || lat != model_lat(3'd4, 20)) begin n_fail++;
      $display("FAIL ignore_start: done=%b result=%h lat=%0d expected 1/00300000/%0d",
               done, result, lat, model_lat(3'd4, 20)); end
    @(negedge clk);
  endtask

  task automatic test_midrun_reset;
    logic [31:0] r; logic e; int lat; bit bok, tmo;
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'hA5A5_0F0F; amt = 5'd20;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, err} !== 3'b000 || result !== 32'h0) begin n_fail++;
      $display("FAIL midrun_reset: busy/done/err=%b result=%h expected 000/00000000", {busy, done, err}, result); end
    @(negedge clk); clr_n = 1'b1;
    exec_cmd(3'd3, 32'h1234_5678, 5'd8, r, e, lat, bok, tmo);
    n_checks++; if (tmo || r !== 32'h7812_3456 || e !== 1'b0 || lat != model_lat(3'd3, 8)) begin n_fail++;
      $display("FAIL post_reset_cmd: result=%h err=%b lat=%0d expected 78123456/0/%0d", r, e, lat, model_lat(3'd3, 8)); end
  endtask

  task automatic test_back_to_back;
    int pos[$];
    logic prev_done;
    int exp_lat;
    exp_lat = model_lat(3'd4, 6);
    prev_done = 1'b0;
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'h1234_5678; amt = 5'd6;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pos.push_back(c);
        n_checks++; if (prev_done || result !== 32'h8D15_9E04) begin n_fail++;
          $display("FAIL b2b_pulse: cycle %0d prev_done=%b result=%h expected 0/8d159e04", c, prev_done, result); end
      end
      prev_done = done;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++; if (pos.size() < 3) begin n_fail++;
      $display("FAIL b2b_count: got %0d done pulses expected at least 3", pos.size()); end
    else begin
      n_checks++; if (pos[0] != exp_lat) begin n_fail++;
        $display("FAIL b2b_first: got %0d expected %0d", pos[0], exp_lat); end
      for (int i = 1; i < pos.size(); i++) begin
        n_checks++; if (pos[i] - pos[i-1] != exp_lat + 2) begin n_fail++;
          $display("FAIL b2b_period: got %0d expected %0d", pos[i] - pos[i-1], exp_lat + 2); end
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] r, av, er; logic e; int lat; bit bok, tmo;
    logic [2:0] o; logic [4:0] n;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7)); n = 5'($urandom); av = $urandom;
      er = model_res(o, av, int'(n));
      exec_cmd(o, av, n, r, e, lat, bok, tmo);
      n_checks++; if (tmo || r !== er || e !== (o > 3'd4) || !bok) begin n_fail++;
        $display("FAIL rnd%0d_result: op=%0d a=%h amt=%0d got %h err=%b busy_ok=%0d expected %h err=%b",
                 i, o, av, n, r, e, bok, er, (o > 3'd4)); end
      n_checks++; if (lat != model_lat(o, int'(n))) begin n_fail++;
        $display("FAIL rnd%0d_latency: op=%0d amt=%0d got %0d expected %0d", i, o, n, lat, model_lat(o, int'(n))); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal_err();
    test_ignore_start();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
